// File: rtl/arena_uart_packer.sv
// Arena state packetiser: snapshots the game state on a frame tick and
// streams a 44-byte checksummed packet to a byte-wide UART transmitter.
module arena_uart_packer #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_frame_tick,
  input  logic [99:0]  i_arena_0,
  input  logic [99:0]  i_bombs_0,
  input  logic [99:0]  i_bombs_1,
  input  logic [3:0]   i_playerAx,
  input  logic [3:0]   i_playerAy,
  input  logic [3:0]   i_playerBx,
  input  logic [3:0]   i_playerBy,
  input  logic [1:0]   i_healthA,
  input  logic [1:0]   i_healthB,
  input  logic [1:0]   i_game_state,
  input  logic         i_tx_busy,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_stb,
  output logic         o_active,
  output logic [7:0]   o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [5:0]  LAST    = 6'd43;

  state_t       state;
  logic         tick_q;
  logic [5:0]   idx;
  logic [7:0]   chk;
  logic [7:0]   data_q;
  logic [15:0]  to_cnt;

  logic [103:0] ar_s;
  logic [103:0] b0_s;
  logic [103:0] b1_s;
  logic [7:0]   pa_s;
  logic [7:0]   pb_s;
  logic [7:0]   hs_s;

  logic         tick_edge;
  logic         launch;
  logic [5:0]   k;
  logic [6:0]   off;
  logic [7:0]   cur;

  assign tick_edge = i_frame_tick & ~tick_q;
  assign launch    = tick_edge & i_en & (state == IDLE);

  // Map bytes: group-relative index k selects bits [8k+7:8k];
  // the top 4 bits of each padded map are constant zero.
  always_comb begin
    cur = 8'h00;
    k   = 6'd0;
    unique case (1'b1)
      idx == 6'd0: cur = HEADER;
      idx == 6'd1: cur = pa_s;
      idx == 6'd2: cur = pb_s;
      idx == 6'd3: cur = hs_s;
      idx >= 6'd4 && idx <= 6'd16: begin
        k   = idx - 6'd4;
        cur = ar_s[{k[3:0], 3'b000} +: 8];
      end
      idx >= 6'd17 && idx <= 6'd29: begin
        k   = idx - 6'd17;
        cur = b0_s[{k[3:0], 3'b000} +: 8];
      end
      idx >= 6'd30 && idx <= 6'd42: begin
        k   = idx - 6'd30;
        cur = b1_s[{k[3:0], 3'b000} +: 8];
      end
      idx == LAST: cur = chk;
      default: cur = 8'h00;
    endcase
  end

  assign off = {k[3:0], 3'b000};

  // Strobe only when the UART is free; data is held between strobes.
  assign o_tx_stb  = (state == SEND) & ~i_tx_busy;
  assign o_tx_data = o_tx_stb ? cur : data_q;

  always_ff @(posedge clk) begin
    if (launch) begin
      ar_s <= {4'h0, i_arena_0};
      b0_s <= {4'h0, i_bombs_0};
      b1_s <= {4'h0, i_bombs_1};
      pa_s <= {i_playerAx, i_playerAy};
      pb_s <= {i_playerBx, i_playerBy};
      hs_s <= {i_healthA, i_healthB, i_game_state, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_q     <= 1'b1;
      idx        <= 6'd0;
      chk        <= 8'h00;
      data_q     <= 8'h00;
      to_cnt     <= 16'd0;
      o_active   <= 1'b0;
      o_drop_cnt <= 8'h00;
    end else begin
      tick_q <= i_frame_tick;
      if (tick_edge && i_en && state != IDLE && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state    <= SEND;
            o_active <= 1'b1;
            idx      <= 6'd0;
            chk      <= 8'h00;
          end
        end
        SEND: begin
          if (!i_tx_busy) begin
            data_q <= cur;
            idx    <= idx + 6'd1;
            to_cnt <= 16'd0;
            state  <= WAIT_HI;
            if (idx != 6'd0 && idx != LAST)
              chk <= chk ^ cur;
          end
        end
        WAIT_HI: begin
          if (i_tx_busy || to_cnt == TO_LAST)
            state <= WAIT_LO;
          else
            to_cnt <= to_cnt + 16'd1;
        end
        WAIT_LO: begin
          if (!i_tx_busy) begin
            if (idx == LAST + 6'd1) begin
              state    <= IDLE;
              o_active <= 1'b0;
              idx      <= 6'd0;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = ^off;

endmodule

// File: tb/tb_arena_uart_packer.sv
// Directed bench for arena_uart_packer: packet content, timing,
// drops, reset abort and enable gating.
module tb_arena_uart_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_frame_tick = 1'b0;
  logic [99:0] i_arena_0 = '0;
  logic [99:0] i_bombs_0 = '0;
  logic [99:0] i_bombs_1 = '0;
  logic [3:0]  i_playerAx = '0;
  logic [3:0]  i_playerAy = '0;
  logic [3:0]  i_playerBx = '0;
  logic [3:0]  i_playerBy = '0;
  logic [1:0]  i_healthA = '0;
  logic [1:0]  i_healthB = '0;
  logic [1:0]  i_game_state = '0;
  logic        i_tx_busy = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_stb;
  logic        o_active;
  logic [7:0]  o_drop_cnt;

  arena_uart_packer dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .i_frame_tick (i_frame_tick),
    .i_arena_0    (i_arena_0),
    .i_bombs_0    (i_bombs_0),
    .i_bombs_1    (i_bombs_1),
    .i_playerAx   (i_playerAx),
    .i_playerAy   (i_playerAy),
    .i_playerBx   (i_playerBx),
    .i_playerBy   (i_playerBy),
    .i_healthA    (i_healthA),
    .i_healthB    (i_healthB),
    .i_game_state (i_game_state),
    .i_tx_busy    (i_tx_busy),
    .o_tx_data    (o_tx_data),
    .o_tx_stb     (o_tx_stb),
    .o_active     (o_active),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q[$];
  int         qt[$];
  logic [7:0] exp_b[44];
  bit         s_now;
  bit         prev_stb = 1'b0;
  bit         consec = 1'b0;
  bit         uart_on = 1'b0;
  bit         pend = 1'b0;
  int         bcnt = 0;

  // Byte capture plus a UART model: busy for 10 cycles, starting one
  // cycle after each strobe.
  always @(negedge clk) begin
    s_now = o_tx_stb;
    if (s_now) begin
      q.push_back(o_tx_data);
      qt.push_back(cyc);
    end
    if (s_now && prev_stb) consec = 1'b1;
    prev_stb = s_now;
    if (!uart_on) begin
      i_tx_busy = 1'b0;
      pend = 1'b0;
      bcnt = 0;
    end else if (pend) begin
      pend = 1'b0;
      i_tx_busy = 1'b1;
      bcnt = 10;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) i_tx_busy = 1'b0;
    end
    if (s_now && uart_on) pend = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp();
    logic [103:0] a, x, y;
    logic [7:0]   c;
    a = {4'h0, i_arena_0};
    x = {4'h0, i_bombs_0};
    y = {4'h0, i_bombs_1};
    exp_b[0] = 8'hA5;
    exp_b[1] = {i_playerAx, i_playerAy};
    exp_b[2] = {i_playerBx, i_playerBy};
    exp_b[3] = {i_healthA, i_healthB, i_game_state, 2'b00};
    for (int k = 0; k < 13; k++) begin
      exp_b[4 + k]  = a[8*k +: 8];
      exp_b[17 + k] = x[8*k +: 8];
      exp_b[30 + k] = y[8*k +: 8];
    end
    c = 8'h00;
    for (int i = 1; i < 43; i++) c = c ^ exp_b[i];
    exp_b[43] = c;
  endtask

  task automatic tick_edge();
    @(negedge clk) i_frame_tick = 1'b0;
    @(negedge clk) i_frame_tick = 1'b0;
    @(negedge clk) i_frame_tick = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!o_active) break;
    end
  endtask

  task automatic wait_bytes(input int n, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (q.size() >= n) break;
    end
  endtask

  task automatic cmp_pkt(input string tag);
    int bad;
    check({tag, "_count"}, q.size(), 44);
    while (q.size() < 44) q.push_back(8'hxx);
    bad = 0;
    for (int i = 0; i < 44; i++)
      if (q[i] !== exp_b[i]) bad++;
    check({tag, "_bytes"}, bad, 0);
  endtask

  logic [7:0] acc;
  logic       allff;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_stb", o_tx_stb, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_active", o_active, 0);
    check("rst_drop", o_drop_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Golden packet with a busy UART
    i_playerAx = 4'd1; i_playerAy = 4'd1;
    i_playerBx = 4'd8; i_playerBy = 4'd8;
    i_healthA = 2'd3; i_healthB = 2'd2; i_game_state = 2'd0;
    i_arena_0 = 100'd1 << 13;
    uart_on = 1'b1;
    i_en = 1'b1;
    build_exp();
    q.delete(); qt.delete();
    @(negedge clk) i_frame_tick = 1'b1;
    @(negedge clk);
    check("t1_first_stb", o_tx_stb, 1);
    check("t1_first_data", o_tx_data, 8'hA5);
    check("t1_active", o_active, 1);
    i_playerAx = 4'hF;
    i_arena_0 = '1;
    wait_idle(2000);
    check("t1_done", o_active, 0);
    cmp_pkt("t1");
    check("t1_b1", q[1], 8'h11);
    check("t1_b2", q[2], 8'h88);
    check("t1_b3", q[3], 8'hE0);
    check("t1_b4", q[4], 8'h00);
    check("t1_b5", q[5], 8'h20);
    acc = 8'h00;
    for (int i = 17; i < 43; i++) acc = acc | q[i];
    check("t1_bombs_zero", acc, 8'h00);
    check("t1_chk", q[43], 8'h59);

    // UART never asserts busy: timeout path
    i_playerAx = 4'd1;
    i_arena_0 = 100'd1 << 13;
    uart_on = 1'b0;
    build_exp();
    q.delete(); qt.delete();
    tick_edge();
    wait_idle(2000);
    check("t2_done", o_active, 0);
    cmp_pkt("t2");
    while (qt.size() < 44) qt.push_back(0);
    check("t2_gap_first", qt[1] - qt[0], 18);
    check("t2_gap_last", qt[43] - qt[42], 18);

    // Ticks during a packet are dropped
    uart_on = 1'b1;
    i_arena_0 = {4'h9, 96'h0123456789ABCDEF00112233};
    i_bombs_0 = {4'h3, 96'hFEDCBA987654321000C0FFEE};
    i_bombs_1 = {4'hC, 96'h5A5A5A5A0F0F0F0F12345678};
    build_exp();
    q.delete(); qt.delete();
    tick_edge();
    for (int j = 0; j < 3; j++) begin
      repeat (40) @(negedge clk);
      i_frame_tick = 1'b0;
      i_arena_0 = ~i_arena_0;
      repeat (5) @(negedge clk);
      i_frame_tick = 1'b1;
    end
    wait_idle(2000);
    check("t3_done", o_active, 0);
    check("t3_drop", o_drop_cnt, 3);
    cmp_pkt("t3");
    repeat (60) @(negedge clk);
    check("t3_no_extra", q.size(), 44);

    // Reset mid-packet with the tick held high
    build_exp();
    q.delete(); qt.delete();
    tick_edge();
    wait_bytes(20, 1000);
    check("t4_reach20", q.size() >= 20, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_stb", o_tx_stb, 0);
    check("t4_active", o_active, 0);
    check("t4_drop", o_drop_cnt, 0);
    q.delete(); qt.delete();
    repeat (100) @(negedge clk);
    check("t4_quiet", q.size(), 0);
    check("t4_idle", o_active, 0);
    tick_edge();
    @(negedge clk);
    check("t4_relaunch", o_active, 1);
    wait_idle(2000);
    cmp_pkt("t4");

    // Enable gating
    i_en = 1'b0;
    q.delete(); qt.delete();
    tick_edge();
    repeat (50) @(negedge clk);
    check("t5_no_stb", q.size(), 0);
    check("t5_drop", o_drop_cnt, 0);
    check("t5_idle", o_active, 0);
    i_en = 1'b1;
    build_exp();
    tick_edge();
    wait_bytes(5, 500);
    i_en = 1'b0;
    wait_idle(2000);
    check("t5_done", o_active, 0);
    cmp_pkt("t5");

    // All-ones maps
    i_en = 1'b1;
    i_arena_0 = '1; i_bombs_0 = '1; i_bombs_1 = '1;
    i_playerAx = 4'd2; i_playerAy = 4'd3;
    i_playerBx = 4'd4; i_playerBy = 4'd5;
    i_healthA = 2'd1; i_healthB = 2'd1; i_game_state = 2'd2;
    build_exp();
    q.delete(); qt.delete();
    tick_edge();
    wait_idle(2000);
    cmp_pkt("t6");
    check("t6_b16", q[16], 8'h0F);
    check("t6_b29", q[29], 8'h0F);
    check("t6_b42", q[42], 8'h0F);
    allff = 1'b1;
    for (int i = 4; i < 43; i++)
      if (i != 16 && i != 29 && i != 42 && q[i] !== 8'hFF) allff = 1'b0;
    check("t6_ff", allff, 1);
    acc = 8'h00;
    for (int i = 1; i < 43; i++) acc = acc ^ q[i];
    check("t6_xor", q[43], acc);
    check("t6_chk", q[43], 8'h31);

    check("no_consec_stb", consec, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
